// File: rtl/regfile_sb.sv
// Register file with two combinational read ports, one write port, optional write-to-read
// bypass, and a busy-bit scoreboard that decode reserves and writeback releases.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int ADDR_W   = $clog2(NREGS),
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic              o_rs1_busy,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic [XLEN-1:0]   o_rs2_data,
  output logic              o_rs2_busy,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [XLEN-1:0]   i_wr_data,
  input  logic              i_rsv_en,
  input  logic [ADDR_W-1:0] i_rsv_addr,
  output logic              o_rsv_ack,
  input  logic              i_flush,
  output logic [ADDR_W:0]   o_busy_cnt
);

  localparam logic [ADDR_W:0] NREGS_L = (ADDR_W+1)'(NREGS);

  logic [XLEN-1:0]  r_mem [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [ADDR_W:0]  r_busy_cnt;

  logic             w_wr_vld;
  logic             w_rsv_vld;
  logic             w_releasing;
  logic [NREGS-1:0] w_busy_nxt;
  logic [ADDR_W:0]  w_cnt_nxt;

  function automatic logic f_valid(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS_L) && !(ZERO_REG && (a == '0));
  endfunction

  assign w_wr_vld    = i_wr_en && f_valid(i_wr_addr);
  assign w_rsv_vld   = i_rsv_en && f_valid(i_rsv_addr);
  assign w_releasing = i_wr_en && (i_wr_addr == i_rsv_addr);
  assign o_rsv_ack   = w_rsv_vld && !i_flush && !i_rst &&
                       (!r_busy[i_rsv_addr] || w_releasing);

  // Reserve is applied after the release so a same-address write+reserve ends busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      if (w_wr_vld) w_busy_nxt[i_wr_addr] = 1'b0;
      if (o_rsv_ack) w_busy_nxt[i_rsv_addr] = 1'b1;
    end
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_cnt_nxt = w_cnt_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_wr_vld) r_mem[i_wr_addr] <= i_wr_data;
      r_busy     <= w_busy_nxt;
      r_busy_cnt <= w_cnt_nxt;
    end
  end

  assign o_busy_cnt = r_busy_cnt;

  always_comb begin
    o_rs1_data = '0;
    o_rs1_busy = 1'b0;
    if (f_valid(i_rs1_addr)) begin
      if (BYPASS && !i_rst && i_wr_en && (i_wr_addr == i_rs1_addr)) begin
        o_rs1_data = i_wr_data;
      end else begin
        o_rs1_data = r_mem[i_rs1_addr];
        o_rs1_busy = r_busy[i_rs1_addr];
      end
    end
  end

  always_comb begin
    o_rs2_data = '0;
    o_rs2_busy = 1'b0;
    if (f_valid(i_rs2_addr)) begin
      if (BYPASS && !i_rst && i_wr_en && (i_wr_addr == i_rs2_addr)) begin
        o_rs2_data = i_wr_data;
      end else begin
        o_rs2_data = r_mem[i_rs2_addr];
        o_rs2_busy = r_busy[i_rs2_addr];
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: a default instance (32 regs, bypass) and a 20-reg no-bypass instance share stimulus.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [AW-1:0]   rs1_addr, rs2_addr, wr_addr, rsv_addr;
  logic [XLEN-1:0] wr_data;
  logic            wr_en, rsv_en, flush;

  logic [XLEN-1:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
  logic            a_rs1_busy, a_rs2_busy, b_rs1_busy, b_rs2_busy;
  logic            a_rsv_ack, b_rsv_ack;
  logic [AW:0]     a_busy_cnt, b_busy_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_sb dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_rs1_addr(rs1_addr), .o_rs1_data(a_rs1_data), .o_rs1_busy(a_rs1_busy),
    .i_rs2_addr(rs2_addr), .o_rs2_data(a_rs2_data), .o_rs2_busy(a_rs2_busy),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_rsv_ack(a_rsv_ack),
    .i_flush(flush), .o_busy_cnt(a_busy_cnt)
  );

  regfile_sb #(.NREGS(20), .BYPASS(1'b0)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_rs1_addr(rs1_addr), .o_rs1_data(b_rs1_data), .o_rs1_busy(b_rs1_busy),
    .i_rs2_addr(rs2_addr), .o_rs2_data(b_rs2_data), .o_rs2_busy(b_rs2_busy),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rsv_en(rsv_en), .i_rsv_addr(rsv_addr), .o_rsv_ack(b_rsv_ack),
    .i_flush(flush), .o_busy_cnt(b_busy_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
    wr_addr = '0; wr_data = '0; rsv_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic rsv(input logic [AW-1:0] a);
    rsv_en = 1'b1; rsv_addr = a;
  endtask

  initial begin
    rst = 1'b1; idle(); rs1_addr = '0; rs2_addr = '0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset mid-operation
    wr(5, 32'hDEADBEEF); rsv(6);
    tick();
    idle(); rs1_addr = 5; settle();
    chk("pre_rst_x5", a_rs1_data, 32'hDEADBEEF);
    chk("pre_rst_cnt", a_busy_cnt, 1);
    wr(5, 32'h11111111); rsv(7);
    rst = 1'b1; settle();
    chk("rst_x5_zero", a_rs1_data, 0);
    chk("rst_cnt", a_busy_cnt, 0);
    chk("rst_ack", a_rsv_ack, 0);
    tick();
    idle(); rst = 1'b0;
    tick();
    chk("post_rst_x5", a_rs1_data, 0);
    chk("post_rst_cnt", a_busy_cnt, 0);

    // Plain write/read and x0
    wr(7, 32'h12345678); tick();
    wr(0, 32'hFFFFFFFF); rs2_addr = 0; settle();
    chk("x0_bypass_blocked", a_rs2_data, 0);
    tick();
    idle(); rs1_addr = 7; rs2_addr = 0; settle();
    chk("rd_x7", a_rs1_data, 32'h12345678);
    chk("rd_x0", a_rs2_data, 0);
    chk("rd_x0_busy", a_rs2_busy, 0);
    chk("b_rd_x7", b_rs1_data, 32'h12345678);
    rsv(0); settle();
    chk("rsv_x0_ack", a_rsv_ack, 0);
    idle();

    // Bypass
    wr(3, 32'h1); tick();
    wr(3, 32'hAA); rs1_addr = 3; settle();
    chk("byp_same_cycle", a_rs1_data, 32'hAA);
    chk("nobyp_old", b_rs1_data, 32'h1);
    tick();
    idle(); settle();
    chk("nobyp_next", b_rs1_data, 32'hAA);

    // Scoreboard reserve / reject / release
    rsv(4); rs2_addr = 4; settle();
    chk("rsv_x4_ack", a_rsv_ack, 1);
    tick();
    chk("rsv_x4_cnt", a_busy_cnt, 1);
    chk("rsv_x4_busy", a_rs2_busy, 1);
    chk("rsv_x4_again", a_rsv_ack, 0);
    idle(); wr(4, 32'h44); settle();
    chk("rel_byp_busy", a_rs2_busy, 0);
    chk("rel_nobyp_busy", b_rs2_busy, 1);
    chk("rel_cnt_before", a_busy_cnt, 1);
    tick();
    idle(); settle();
    chk("rel_cnt_after", a_busy_cnt, 0);
    chk("rel_busy_after", a_rs2_busy, 0);

    // Same-address write and reserve on a busy register
    rsv(9); tick();
    idle(); wr(9, 32'h99); rsv(9); settle();
    chk("wr_rsv_ack", a_rsv_ack, 1);
    tick();
    idle(); rs1_addr = 9; settle();
    chk("wr_rsv_data", a_rs1_data, 32'h99);
    chk("wr_rsv_busy", a_rs1_busy, 1);
    chk("wr_rsv_cnt", a_busy_cnt, 1);
    wr(9, 32'h9A); tick();
    idle(); settle();
    chk("x9_release_cnt", a_busy_cnt, 0);

    // Flush
    rsv(1); tick(); rsv(2); tick(); rsv(3); tick();
    idle(); settle();
    chk("pre_flush_cnt", a_busy_cnt, 3);
    flush = 1'b1; rsv(6); wr(2, 32'h55); settle();
    chk("flush_ack", a_rsv_ack, 0);
    tick();
    idle(); rs1_addr = 2; rs2_addr = 6; settle();
    chk("flush_cnt", a_busy_cnt, 0);
    chk("flush_x2", a_rs1_data, 32'h55);
    chk("flush_x6_busy", a_rs2_busy, 0);
    rs1_addr = 3; settle();
    chk("flush_x3_kept", a_rs1_data, 32'hAA);
    chk("flush_x3_busy", a_rs1_busy, 0);

    // Out-of-range address on the 20-register instance
    rsv(25); rs1_addr = 25; settle();
    chk("oor_ack_b", b_rsv_ack, 0);
    chk("oor_ack_a", a_rsv_ack, 1);
    chk("oor_rd_b", b_rs1_data, 0);
    tick();
    idle(); settle();
    chk("oor_cnt_a", a_busy_cnt, 1);
    chk("oor_cnt_b", b_busy_cnt, 0);
    chk("oor_busy_b", b_rs1_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
